// File: rtl/ctrl_pipe_pkg.sv
// ctrl_pipe_pkg
// Shared types and defaults for the control-signal pipeline:
//   - mult_state_e : multiplier interlock FSM states
//   - DEF_*        : default parameter values of ctrl_pipeline
//   - CNT_W        : multiplier counter width for the default latency
//   - cnt_width()  : counter width for an arbitrary latency (never 0)
package ctrl_pipe_pkg;

  typedef enum logic {
    MS_IDLE = 1'b0,
    MS_BUSY = 1'b1
  } mult_state_e;

  localparam int DEF_CTRL_W   = 13;
  localparam int DEF_NSTAGES  = 3;
  localparam int DEF_MULT_LAT = 4;
  localparam int DEF_MULT_BIT = 2;
  localparam int DEF_HILO_BIT = 0;

  localparam int CNT_W = $clog2(DEF_MULT_LAT);

  // A latency of 1 would give a zero-width counter; keep at least one bit.
  function automatic int cnt_width(input int lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/dreg_en_clr.sv
// dreg_en_clr
// One pipeline stage register with hold and synchronous clear.
// Ports:
//   clk  in          rising-edge clock
//   rst  in          asynchronous active-low reset (clears q)
//   en   in          load d when high (low = hold)
//   clr  in          load all-zero; takes priority over en
//   d    in  WIDTH   next value
//   q    out WIDTH   registered value
module dreg_en_clr
  import ctrl_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
// Carries the decoded control bundle from Decode through NSTAGES stage
// registers (0 = E, 1 = M, 2 = W), each with its own stall and flush, and
// owns the multi-cycle multiplier interlock.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-low reset
//   ctrl_d     in   CTRL_W          control bundle from the decoders
//   valid_d    in   1               ctrl_d is a real instruction
//   stall      in   NSTAGES         per-stage hold request
//   flush      in   NSTAGES         per-stage bubble request
//   ctrl_q     out  NSTAGES*CTRL_W  stage k bundle at [k*CTRL_W +: CTRL_W]
//   valid_q    out  NSTAGES         per-stage valid
//   stall_up   out  1               Fetch/Decode must hold this cycle
//   mult_busy  out  1               a multiply is in flight
//   mult_done  out  1               pulse in the last busy cycle
module ctrl_pipeline
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W   = DEF_CTRL_W,
  parameter int NSTAGES  = DEF_NSTAGES,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int MULT_BIT = DEF_MULT_BIT,
  parameter int HILO_BIT = DEF_HILO_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CTRL_W-1:0]         ctrl_d,
  input  logic                      valid_d,
  input  logic [NSTAGES-1:0]        stall,
  input  logic [NSTAGES-1:0]        flush,
  output logic [NSTAGES*CTRL_W-1:0] ctrl_q,
  output logic [NSTAGES-1:0]        valid_q,
  output logic                      stall_up,
  output logic                      mult_busy,
  output logic                      mult_done
);

  localparam int            CW       = cnt_width(MULT_LAT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(MULT_LAT - 1);

  mult_state_e        r_state, w_state_nxt;
  logic [CW-1:0]      r_cnt, w_cnt_nxt;
  logic [NSTAGES-1:0] w_hold;
  logic               w_mult_stall;
  logic               w_is_mult;
  logic               w_is_hilo;

  // Stage 0 occupies the low CTRL_W bits of ctrl_q.
  assign w_is_mult = valid_q[0] & ctrl_q[MULT_BIT];
  assign w_is_hilo = valid_q[0] & ctrl_q[HILO_BIT];

  // A held stage forces every older-side (upstream) stage to hold too; the
  // multiplier interlock only ever holds stage 0 and upstream.
  always_comb begin
    w_hold = '0;
    w_hold[NSTAGES-1] = stall[NSTAGES-1];
    for (int k = NSTAGES - 2; k >= 0; k--) begin
      w_hold[k] = stall[k] | w_hold[k+1];
    end
    w_hold[0] = w_hold[0] | w_mult_stall;
  end

  assign stall_up = w_hold[0];

  for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
    logic [CTRL_W:0] w_d;
    logic [CTRL_W:0] w_q;
    logic            w_clr;

    if (k == 0) begin : g_first
      assign w_d   = {valid_d, ctrl_d};
      assign w_clr = flush[0];
    end else begin : g_rest
      assign w_d   = {valid_q[k-1], ctrl_q[(k-1)*CTRL_W +: CTRL_W]};
      // Upstream is held but this stage moves: insert a bubble so the held
      // instruction is not also copied forward.
      assign w_clr = flush[k] | (~w_hold[k] & w_hold[k-1]);
    end

    dreg_en_clr #(
      .WIDTH(CTRL_W + 1)
    ) u_reg (
      .clk(clk),
      .rst(rst),
      .en (~w_hold[k]),
      .clr(w_clr),
      .d  (w_d),
      .q  (w_q)
    );

    assign ctrl_q[k*CTRL_W +: CTRL_W] = w_q[CTRL_W-1:0];
    assign valid_q[k]                 = w_q[CTRL_W];
  end

  // Multiplier interlock state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= MS_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The counter runs regardless of stalls; the initiating multiply is never
  // held by the FSM, only a younger multiply or HI/LO read sitting in stage 0.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    mult_busy    = 1'b0;
    mult_done    = 1'b0;
    w_mult_stall = 1'b0;
    case (r_state)
      MS_IDLE: begin
        if (w_is_mult && !flush[0]) begin
          w_state_nxt = MS_BUSY;
          w_cnt_nxt   = CNT_LOAD;
        end
      end
      MS_BUSY: begin
        mult_busy    = 1'b1;
        w_mult_stall = w_is_mult | w_is_hilo;
        if (r_cnt == '0) begin
          mult_done   = 1'b1;
          w_state_nxt = MS_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = MS_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
